serial_a_paralelo_com: RTL

Receive-side counterpart of the serial IDLE/COM transmitter: consumes the MSB-first serial bit stream on `clk32f`, finds byte alignment by hunting for the COM symbol 0xBC, and declares the link active after a configurable run of aligned COMs. Once active it emits one parallel byte with a one-cycle valid strobe every 8 clocks. It sits directly downstream of the serializer in the physical-layer loopback.

---
 rtl/serial_phy_pkg.sv | 19 +
 rtl/serial_a_paralelo_com_if.sv | 12 +
 rtl/serial_shift8.sv | 31 +++
 rtl/serial_a_paralelo_com.sv | 118 +++++++++++
 4 files changed

// File: rtl/serial_phy_pkg.sv
// Shared definitions for the serial physical-layer blocks: line symbols,
// receiver state encoding and a small saturating-counter helper.
package serial_phy_pkg;

    localparam logic [7:0] COM_SYM  = 8'hBC;
    localparam logic [7:0] IDLE_SYM = 8'h7C;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } sp_state_t;

    // Increment a 3-bit count, sticking at 7 instead of wrapping
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/serial_a_paralelo_com_if.sv
// Serial-in / parallel-out bus of the COM-aligning deserializer.
// master: the stimulus side (drives the serial bit, observes the byte side).
// slave:  the deserializer itself.
interface serial_a_paralelo_com_if;
    logic       in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (output in, input data_out, input valid_out, input active);
    modport slave  (input in, output data_out, output valid_out, output active);
endinterface

// File: rtl/serial_shift8.sv
// 8-bit MSB-first shift register plus modulo-8 bit counter. The counter can
// be resynchronised so that the byte following a detected COM begins at bit 1;
// o_boundary marks the cycle in which the shift register holds a whole
// aligned byte.
module serial_shift8 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_bit,
    input  logic       i_sync,
    output logic [7:0] o_shreg,
    output logic       o_boundary
);
    logic [7:0] r_shreg;
    logic [2:0] r_bit_cnt;

    // Shift one serial bit in per edge, oldest bit ends up in the MSB
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_shreg <= '0;
        else          r_shreg <= {r_shreg[6:0], i_bit};
    end

    // Free-running modulo-8 counter, restarted at 1 when alignment is found
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_bit_cnt <= '0;
        else if (i_sync) r_bit_cnt <= 3'd1;
        else             r_bit_cnt <= r_bit_cnt + 3'd1;
    end

    assign o_shreg    = r_shreg;
    assign o_boundary = (r_bit_cnt == 3'd0);
endmodule

// File: rtl/serial_a_paralelo_com.sv
// COM-aligning serial-to-parallel receiver. Hunts bit-by-bit for the COM
// symbol, confirms alignment with a run of COM_COUNT byte-aligned COMs, then
// emits every aligned byte with a one-cycle strobe.
// Optional build macro: SP_IDLE_FILTER_EN -- when defined, COM and IDLE bytes
// received while active are dropped (no strobe, data_out unchanged).
module serial_a_paralelo_com
    import serial_phy_pkg::*;
#(
    parameter int unsigned COM_COUNT   = 4,     // legal 1..7
    parameter logic [7:0]  COM_SYMBOL  = COM_SYM,
    parameter logic [7:0]  IDLE_SYMBOL = IDLE_SYM
) (
    input  logic                    clk32f,
    input  logic                    reset,      // asynchronous, active low
    serial_a_paralelo_com_if.slave  bus
);
`ifdef SP_IDLE_FILTER_EN
    localparam logic FILTER_EN = 1'b1;
`else
    localparam logic FILTER_EN = 1'b0;
`endif
    localparam logic [2:0] COM_TARGET = 3'(COM_COUNT);

    sp_state_t  r_state, w_state_nxt;
    logic [2:0] r_com_cnt, w_com_cnt_nxt, w_com_inc;
    logic [7:0] r_data, w_data_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_active, w_active_nxt;

    logic [7:0] w_shreg;
    logic       w_boundary;
    logic       w_sync;
    logic       w_is_com;
    logic       w_keep;

    serial_shift8 u_shift (
        .i_clk      (clk32f),
        .i_rst_n    (reset),
        .i_bit      (bus.in),
        .i_sync     (w_sync),
        .o_shreg    (w_shreg),
        .o_boundary (w_boundary)
    );

    assign w_is_com  = (w_shreg == COM_SYMBOL);
    assign w_com_inc = sat_inc3(r_com_cnt);
    // Filler bytes are only suppressed when the filter is built in
    assign w_keep    = !(FILTER_EN && (w_is_com || (w_shreg == IDLE_SYMBOL)));

    // State, COM counter and output registers; everything clears on reset
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_SEARCH;
            r_com_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_com_cnt <= w_com_cnt_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_active  <= w_active_nxt;
        end
    end

    // Alignment FSM: bit-level hunt in SEARCH, byte-level checks afterwards
    always_comb begin
        w_state_nxt   = r_state;
        w_com_cnt_nxt = r_com_cnt;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_active_nxt  = r_active;
        w_sync        = 1'b0;
        unique case (r_state)
            ST_SEARCH: begin
                if (w_is_com) begin
                    w_sync        = 1'b1;
                    w_com_cnt_nxt = 3'd1;
                    if (COM_TARGET == 3'd1) begin
                        w_state_nxt  = ST_ACTIVE;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_com_cnt_nxt = w_com_inc;
                        if (w_com_inc == COM_TARGET) begin
                            w_state_nxt  = ST_ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        // A broken run sends us back to the bit-level hunt
                        w_state_nxt   = ST_SEARCH;
                        w_com_cnt_nxt = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                if (w_boundary && w_keep) begin
                    w_data_nxt  = w_shreg;
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    assign bus.data_out  = r_data;
    assign bus.valid_out = r_valid;
    assign bus.active    = r_active;
endmodule
